// File: rtl/line_arbiter.sv
// Round-robin arbiter/sequencer sharing one draw_line engine between NUM_REQ clients.
// Define LINE_ARB_CLIP_EN to accept-and-drop commands whose start lies off screen.
module line_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_x,
    input  logic [NUM_REQ*7-1:0] req_y,
    input  logic [NUM_REQ*8-1:0] req_xlen,
    input  logic [NUM_REQ*8-1:0] req_ylen,
    output logic [NUM_REQ-1:0]   req_done,
    output logic                 start_line,
    output logic [7:0]           start_x_pos,
    output logic [6:0]           start_y_pos,
    output logic [7:0]           x_length,
    output logic [7:0]           y_length,
    input  logic                 running,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy
);

    typedef enum logic [2:0] {ARB, LAUNCH, WAIT_RUN, WAIT_DONE, DONE} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, gid_q, win_idx, ptr_nxt;
    logic [7:0]      x_q, xlen_q, ylen_q;
    logic [6:0]      y_q;
    logic            win_found, xfer, clip;
    logic [7:0]      win_x, win_xlen, win_ylen;
    logic [6:0]      win_y;

    // First valid requester at or after the priority pointer, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    assign win_x    = req_x[int'(win_idx)*8 +: 8];
    assign win_y    = req_y[int'(win_idx)*7 +: 7];
    assign win_xlen = req_xlen[int'(win_idx)*8 +: 8];
    assign win_ylen = req_ylen[int'(win_idx)*8 +: 8];
    assign ptr_nxt  = (int'(win_idx) == NUM_REQ-1) ? '0 : win_idx + 1'b1;

`ifdef LINE_ARB_CLIP_EN
    assign clip = (win_x >= 8'd160) || (win_y >= 7'd120);
`else
    assign clip = 1'b0;
`endif

    // The running gate also holds off grants after reset while an orphaned line drains.
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == ARB && !running && win_found)
            req_ready[win_idx] = 1'b1;
    end

    assign xfer = |(req_valid & req_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:       if (xfer) state_d = clip ? DONE : LAUNCH;
            LAUNCH:    state_d = WAIT_RUN;
            WAIT_RUN:  if (running) state_d = WAIT_DONE;
            WAIT_DONE: if (!running) state_d = DONE;
            DONE:      state_d = ARB;
            default:   state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            ptr_q   <= '0;
            gid_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            xlen_q  <= '0;
            ylen_q  <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                ptr_q <= ptr_nxt;
                gid_q <= win_idx;
                if (!clip) begin
                    x_q    <= win_x;
                    y_q    <= win_y;
                    xlen_q <= win_xlen;
                    ylen_q <= win_ylen;
                end
            end
        end
    end

    always_comb begin
        req_done = '0;
        if (state_q == DONE)
            req_done[gid_q] = 1'b1;
    end

    assign start_line  = (state_q == LAUNCH);
    assign busy        = (state_q != ARB);
    assign grant_id    = gid_q;
    assign start_x_pos = x_q;
    assign start_y_pos = y_q;
    assign x_length    = xlen_q;
    assign y_length    = ylen_q;

endmodule

// File: tb/tb_line_arbiter.sv
// Scoreboard bench for line_arbiter with a behavioural draw_line model (no reset, 3-cycle rise).
module tb_line_arbiter;
    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_ready, req_done;
    logic [N-1:0][7:0]    fx = '0, fxl = '0, fyl = '0;
    logic [N-1:0][6:0]    fy = '0;
    logic                 start_line, busy;
    logic [7:0]           start_x_pos, x_length, y_length;
    logic [6:0]           start_y_pos;
    logic [1:0]           grant_id;
    logic                 model_run = 1'b0, force_run = 1'b0;
    wire                  running = model_run | force_run;

    line_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(fx), .req_y(fy), .req_xlen(fxl), .req_ylen(fyl), .req_done(req_done),
        .start_line(start_line), .start_x_pos(start_x_pos), .start_y_pos(start_y_pos),
        .x_length(x_length), .y_length(y_length), .running(running),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int id; logic [7:0] x; logic [6:0] y; logic [7:0] xl; logic [7:0] yl;} launch_t;
    typedef struct {int id; bit clip;} done_t;

    int      q_grant[$];
    launch_t q_launch[$];
    done_t   q_done[$];
    int      reps[N];
    int      total = 0, bad = 0, cyc = 0, t_xfer = 0, t_fall = 0, n_xfer = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmd(input int id, input logic [7:0] x, input logic [6:0] y,
                       input logic [7:0] xl, input logic [7:0] yl, input int n);
        fx[id] = x; fy[id] = y; fxl[id] = xl; fyl[id] = yl;
        reps[id] = n;
    endtask

    task automatic expect_line(input int id, input logic [7:0] x, input logic [6:0] y,
                               input logic [7:0] xl, input logic [7:0] yl, input bit clip);
        launch_t l;
        done_t   d;
        l = '{id, x, y, xl, yl};
        d = '{id, clip};
        q_grant.push_back(id);
        if (!clip) q_launch.push_back(l);
        q_done.push_back(d);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_done"}, 32'(req_done), 0);
        chk({tag, "_start"}, 32'(start_line), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_gid"}, 32'(grant_id), 0);
        chk({tag, "_cmd"}, {start_x_pos, 1'b0, start_y_pos, x_length, y_length}, 0);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        int pend;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            pend = 0;
            for (int r = 0; r < N; r++) pend += reps[r];
            if (!busy && !running && pend == 0 && q_grant.size() == 0 &&
                q_launch.size() == 0 && q_done.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_idle_timeout"}, 32'(ok), 1);
    endtask

    // Requesters hold valid while commands remain; a transfer consumes one.
    task automatic run_drv();
        logic [N-1:0] xf;
        forever begin
            @(negedge clk);
            xf = req_valid & req_ready & {N{~rst}};
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (xf[i] && reps[i] > 0) reps[i]--;
                req_valid[i] = (reps[i] > 0);
            end
        end
    endtask

    // draw_line stand-in: start in T+1, running high from T+4 for max(x_length,1) cycles.
    task automatic run_model();
        int pend = 0, left = 0, len = 1;
        forever begin
            @(negedge clk);
            if (start_line) begin
                pend = 3;
                len  = (x_length == 0) ? 1 : int'(x_length);
            end
            @(posedge clk);
            #1;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin model_run = 1'b1; left = len; end
            end else if (model_run) begin
                left--;
                if (left == 0) model_run = 1'b0;
            end
        end
    endtask

    task automatic run_mon();
        bit           prev_run = 1'b0;
        logic [N-1:0] xf;
        int           e;
        launch_t      l;
        done_t        d;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin prev_run = running; continue; end
            if (prev_run && !running) t_fall = cyc;
            prev_run = running;
            if (req_ready != 0) begin
                chk("ready_onehot", 32'($onehot(req_ready)), 1);
                chk("ready_while_running", 32'(running), 0);
            end
            xf = req_valid & req_ready;
            if (xf != 0) begin
                n_xfer++;
                t_xfer = cyc;
                if (q_grant.size() == 0) chk("grant_unexpected", 32'(xf), 0);
                else begin
                    e = q_grant.pop_front();
                    chk("grant", 32'(xf), 32'(1) << e);
                end
            end
            if (start_line) begin
                chk("start_while_running", 32'(running), 0);
                if (q_launch.size() == 0) chk("launch_unexpected", 32'(start_line), 0);
                else begin
                    l = q_launch.pop_front();
                    chk("launch_latency", cyc, t_xfer + 1);
                    chk("launch_gid", 32'(grant_id), l.id);
                    chk("launch_fields", {start_x_pos, 1'b0, start_y_pos, x_length, y_length},
                        {l.x, 1'b0, l.y, l.xl, l.yl});
                end
            end
            if (req_done != 0) begin
                if (q_done.size() == 0) chk("done_unexpected", 32'(req_done), 0);
                else begin
                    d = q_done.pop_front();
                    chk("done_id", 32'(req_done), 32'(1) << d.id);
                    chk("done_latency", cyc, d.clip ? t_xfer + 1 : t_fall + 1);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) reps[i] = 0;
        fork
            run_drv();
            run_model();
            run_mon();
        join_none

        // Reset with the engine held busy; a request waits behind it.
        force_run = 1'b1;
        cmd(0, 8'd10, 7'd20, 8'd5, 8'd3, 1);
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        expect_line(0, 8'd10, 7'd20, 8'd5, 8'd3, 1'b0);
        @(negedge clk) rst = 1'b0;
        repeat (50) @(posedge clk);
        chk("no_grant_while_running", n_xfer, 0);
        #1 force_run = 1'b0;
        @(negedge clk);
        chk("grant_after_run", 32'(req_ready), 32'b0001);
        wait_idle("single");

        // Two requesters always valid; pointer sits at 1 after the grant to 0.
        cmd(0, 8'd1, 7'd2, 8'd3, 8'd4, 3);
        cmd(1, 8'd30, 7'd40, 8'd2, 8'hFE, 3);
        for (int r = 0; r < 3; r++) begin
            expect_line(1, 8'd30, 7'd40, 8'd2, 8'hFE, 1'b0);
            expect_line(0, 8'd1, 7'd2, 8'd3, 8'd4, 1'b0);
        end
        wait_idle("alternate");

        // Only 2 and 3 valid with pointer at 1: grants 2, 3, 2.
        cmd(2, 8'd50, 7'd60, 8'd1, 8'd0, 2);
        cmd(3, 8'd70, 7'd80, 8'd2, 8'h81, 1);
        expect_line(2, 8'd50, 7'd60, 8'd1, 8'd0, 1'b0);
        expect_line(3, 8'd70, 7'd80, 8'd2, 8'h81, 1'b0);
        expect_line(2, 8'd50, 7'd60, 8'd1, 8'd0, 1'b0);
        wait_idle("skip_idle");

        // Reset during WAIT_DONE: the killed line never reports done.
        cmd(0, 8'd5, 7'd6, 8'd20, 8'd0, 1);
        q_grant.push_back(0);
        q_launch.push_back('{0, 8'd5, 7'd6, 8'd20, 8'd0});
        for (int i = 0; i < 50 && !running; i++) @(negedge clk);
        chk("engine_started", 32'(running), 1);
        repeat (3) @(negedge clk);
        chk("busy_mid_line", 32'(busy), 1);
        #2 rst = 1'b1;
        #1 chk_zero("midreset");
        cmd(1, 8'd9, 7'd9, 8'd1, 8'd1, 1);
        expect_line(1, 8'd9, 7'd9, 8'd1, 8'd1, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        wait_idle("after_reset");

        // Off-screen start from requester 1.
`ifdef LINE_ARB_CLIP_EN
        cmd(1, 8'd200, 7'd5, 8'd3, 8'd0, 1);
        expect_line(1, 8'd200, 7'd5, 8'd3, 8'd0, 1'b1);
        wait_idle("clip");
        chk("clip_regs_held", {start_x_pos, 1'b0, start_y_pos}, {8'd9, 1'b0, 7'd9});
`else
        cmd(1, 8'd200, 7'd5, 8'd3, 8'd0, 1);
        expect_line(1, 8'd200, 7'd5, 8'd3, 8'd0, 1'b0);
        wait_idle("noclip");
`endif

        chk("queues_empty", q_grant.size() + q_launch.size() + q_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
